// File: rtl/present_engine_param.sv
// Iterative PRESENT-64 block cipher (80/128-bit key), one round per clock, with
// valid/ready handshakes and a single-entry cache of the last round key for decrypts.
module present_engine_param #(
  parameter int unsigned KEY_LEN = 80,
  parameter int unsigned ROUNDS  = 31
) (
  input  logic               clk,
  input  logic               iReset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [63:0]        in_data,
  input  logic [KEY_LEN-1:0] in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_data,
  output logic               done,
  output logic               busy,
  output logic               cache_hit
);

  if ((KEY_LEN != 80) && (KEY_LEN != 128)) begin : g_bad_key_len
    $error("present_engine_param: KEY_LEN must be 80 or 128");
  end
  if ((ROUNDS < 1) || (ROUNDS > 31)) begin : g_bad_rounds
    $error("present_engine_param: ROUNDS must be within 1..31");
  end

  localparam int unsigned RC_LO  = (KEY_LEN == 128) ? 62 : 15;
  localparam logic [4:0]  R_LAST = 5'(ROUNDS);

  typedef enum logic [1:0] {IDLE, KEXP, RUN, OUT} state_t;
  state_t state, state_nxt;

  logic [63:0]        data;
  logic [KEY_LEN-1:0] key;
  logic [KEY_LEN-1:0] cache_key;
  logic [KEY_LEN-1:0] cache_rk;
  logic [4:0]         cnt;
  logic               mode;
  logic               cache_valid;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] isbox(input logic [3:0] x);
    case (x)
      4'h0: isbox = 4'h5;  4'h1: isbox = 4'hE;  4'h2: isbox = 4'hF;  4'h3: isbox = 4'h8;
      4'h4: isbox = 4'hC;  4'h5: isbox = 4'h1;  4'h6: isbox = 4'h2;  4'h7: isbox = 4'hD;
      4'h8: isbox = 4'hB;  4'h9: isbox = 4'h4;  4'hA: isbox = 4'h6;  4'hB: isbox = 4'h3;
      4'hC: isbox = 4'h0;  4'hD: isbox = 4'h7;  4'hE: isbox = 4'h9;  default: isbox = 4'hA;
    endcase
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    y = '0;
    for (int unsigned n = 0; n < 16; n++)
      y[4*n +: 4] = inv ? isbox(x[4*n +: 4]) : sbox(x[4*n +: 4]);
    return y;
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 stays put.
  function automatic logic [63:0] p_layer(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    logic [5:0]  j;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      j = (i == 63) ? 6'd63 : 6'((i * 16) % 63);
      if (inv) y[i] = x[j];
      else     y[j] = x[i];
    end
    return y;
  endfunction

  function automatic logic [KEY_LEN-1:0] key_fwd(input logic [KEY_LEN-1:0] k, input logic [4:0] rc);
    logic [KEY_LEN-1:0] r;
    r = {k[KEY_LEN-62:0], k[KEY_LEN-1:KEY_LEN-61]};
    r[KEY_LEN-1 -: 4] = sbox(r[KEY_LEN-1 -: 4]);
    if (KEY_LEN == 128) r[KEY_LEN-5 -: 4] = sbox(r[KEY_LEN-5 -: 4]);
    r[RC_LO +: 5] = r[RC_LO +: 5] ^ rc;
    return r;
  endfunction

  // Exact inverse of key_fwd: undo counter XOR, undo S-boxes, rotate right 61.
  function automatic logic [KEY_LEN-1:0] key_inv(input logic [KEY_LEN-1:0] k, input logic [4:0] rc);
    logic [KEY_LEN-1:0] r;
    r = k;
    r[RC_LO +: 5] = r[RC_LO +: 5] ^ rc;
    if (KEY_LEN == 128) r[KEY_LEN-5 -: 4] = isbox(r[KEY_LEN-5 -: 4]);
    r[KEY_LEN-1 -: 4] = isbox(r[KEY_LEN-1 -: 4]);
    return {r[60:0], r[KEY_LEN-1:61]};
  endfunction

  logic               accept;
  logic               hit;
  logic               last_run;
  logic               last_kexp;
  logic [KEY_LEN-1:0] key_f;
  logic [KEY_LEN-1:0] key_b;
  logic [63:0]        rk;
  logic [63:0]        round_enc;
  logic [63:0]        round_dec;
  logic [63:0]        data_run;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign out_data  = data;

  assign accept    = in_valid && in_ready;
  assign hit       = cache_valid && (in_key == cache_key);
  assign last_run  = mode ? (cnt == 5'd1) : (cnt == R_LAST);
  assign last_kexp = (cnt == R_LAST);
  assign key_f     = key_fwd(key, cnt);
  assign key_b     = key_inv(key, cnt);
  assign rk        = key[KEY_LEN-1 -: 64];
  assign round_enc = p_layer(sbox_layer(data ^ rk, 1'b0), 1'b0);
  assign round_dec = sbox_layer(p_layer(data ^ rk, 1'b1), 1'b1);

  always_comb begin
    data_run = mode ? round_dec : round_enc;
    if (last_run)
      data_run = mode ? (round_dec ^ key_b[KEY_LEN-1 -: 64]) : (round_enc ^ key_f[KEY_LEN-1 -: 64]);
  end

  always_ff @(posedge clk or negedge iReset_n) begin
    if (!iReset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (in_mode && !hit) ? KEXP : RUN;
      KEXP: if (last_kexp) state_nxt = RUN;
      RUN:  if (last_run) state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge iReset_n) begin
    if (!iReset_n) begin
      data        <= '0;
      key         <= '0;
      cache_key   <= '0;
      cache_rk    <= '0;
      cnt         <= '0;
      mode        <= 1'b0;
      cache_valid <= 1'b0;
      cache_hit   <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          data      <= in_data;
          mode      <= in_mode;
          cache_hit <= in_mode && hit;
          if (in_mode && hit) begin
            key <= cache_rk;
            cnt <= R_LAST;
          end else begin
            // Tag is written now and validated only when the final key is stored.
            key         <= in_key;
            cnt         <= 5'd1;
            cache_key   <= in_key;
            cache_valid <= 1'b0;
          end
        end
        KEXP: begin
          key <= key_f;
          cnt <= last_kexp ? R_LAST : cnt + 5'd1;
          if (last_kexp) begin
            cache_rk    <= key_f;
            cache_valid <= 1'b1;
          end
        end
        RUN: begin
          data <= data_run;
          key  <= mode ? key_b : key_f;
          cnt  <= mode ? cnt - 5'd1 : cnt + 5'd1;
          if (last_run) begin
            done <= 1'b1;
            if (!mode) begin
              cache_rk    <= key_f;
              cache_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_present_engine_param.sv
// Randomised self-checking bench for present_engine_param (80- and 128-bit builds)
// against an array/arithmetic PRESENT reference model.
module tb_present_engine_param;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req, sel128, in_mode, out_ready;
  logic [63:0]  in_data;
  logic [127:0] in_key;

  logic        valid80, rdy80, ov80, done80, busy80, hit80;
  logic        valid128, rdy128, ov128, done128, busy128, hit128;
  logic [63:0] od80, od128;
  logic        s_rdy, s_ov, s_done, s_busy, s_hit;
  logic [63:0] s_od;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [3:0] isb [16];

  always #5 clk = ~clk;

  assign valid80  = req && !sel128;
  assign valid128 = req && sel128;
  assign s_rdy  = sel128 ? rdy128  : rdy80;
  assign s_ov   = sel128 ? ov128   : ov80;
  assign s_done = sel128 ? done128 : done80;
  assign s_busy = sel128 ? busy128 : busy80;
  assign s_hit  = sel128 ? hit128  : hit80;
  assign s_od   = sel128 ? od128   : od80;

  present_engine_param #(.KEY_LEN(80), .ROUNDS(31)) dut80 (
    .clk(clk), .iReset_n(rst_n), .in_valid(valid80), .in_ready(rdy80), .in_mode(in_mode),
    .in_data(in_data), .in_key(in_key[79:0]), .out_valid(ov80), .out_ready(out_ready),
    .out_data(od80), .done(done80), .busy(busy80), .cache_hit(hit80));

  present_engine_param #(.KEY_LEN(128), .ROUNDS(31)) dut128 (
    .clk(clk), .iReset_n(rst_n), .in_valid(valid128), .in_ready(rdy128), .in_mode(in_mode),
    .in_data(in_data), .in_key(in_key), .out_valid(ov128), .out_ready(out_ready),
    .out_data(od128), .done(done128), .busy(busy128), .cache_hit(hit128));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [127:0] key_mask(input int len);
    return (len == 128) ? '1 : ((128'd1 << 80) - 128'd1);
  endfunction

  function automatic logic [127:0] m_next_key(input logic [127:0] k, input int len, input int r);
    logic [127:0] n;
    logic [3:0]   nib;
    n = ((k << 61) | (k >> (len - 61))) & key_mask(len);
    nib = 4'(n >> (len - 4));
    n = n ^ (128'(nib ^ sb[nib]) << (len - 4));
    if (len == 128) begin
      nib = 4'(n >> (len - 8));
      n = n ^ (128'(nib ^ sb[nib]) << (len - 8));
    end
    n = n ^ (128'(r) << ((len == 80) ? 15 : 62));
    return n;
  endfunction

  function automatic logic [63:0] m_slayer(input logic [63:0] x, input bit inv);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = inv ? isb[x[4*n +: 4]] : sb[x[4*n +: 4]];
    return y;
  endfunction

  function automatic logic [63:0] m_player(input logic [63:0] x, input bit inv);
    logic [63:0] y;
    int j;
    for (int i = 0; i < 64; i++) begin
      j = (i == 63) ? 63 : (i * 16) % 63;
      if (inv) y[i] = x[j];
      else     y[j] = x[i];
    end
    return y;
  endfunction

  function automatic logic [63:0] m_crypt(input logic [63:0] d, input logic [127:0] key, input int len, input bit dec);
    logic [63:0]  rks [1:32];
    logic [127:0] k;
    logic [63:0]  s;
    k = key & key_mask(len);
    for (int r = 1; r <= 32; r++) begin
      rks[r] = 64'(k >> (len - 64));
      k = m_next_key(k, len, r);
    end
    if (!dec) begin
      s = d;
      for (int r = 1; r <= 31; r++) s = m_player(m_slayer(s ^ rks[r], 0), 0);
      s = s ^ rks[32];
    end else begin
      s = d ^ rks[32];
      for (int r = 31; r >= 1; r--) s = m_slayer(m_player(s, 1), 1) ^ rks[r];
    end
    return s;
  endfunction

  // ---------------- transaction driver ----------------
  task automatic run_op(input logic mode, input logic [63:0] d, input logic [127:0] k, input int hold,
                        output logic [63:0] res, output int lat, output logic hit, output int dones);
    int waitc;
    logic [63:0] held;
    in_mode = mode; in_data = d; in_key = k; req = 1'b1; waitc = 0;
    while (!s_rdy && waitc < 100) begin @(posedge clk); #1; waitc++; end
    if (!s_rdy) check("accept_timeout", 64'(s_rdy), 64'd1);
    @(posedge clk); #1;
    req = 1'b0; in_data = {$urandom, $urandom}; in_key = {$urandom, $urandom, $urandom, $urandom};
    lat = 1; dones = 0;
    while (!s_ov && lat < 200) begin dones += int'(s_done); @(posedge clk); #1; lat++; end
    if (!s_ov) check("result_timeout", 64'(s_ov), 64'd1);
    check("done_with_first_valid", 64'(s_done), 64'd1);
    dones += int'(s_done);
    res = s_od; hit = s_hit; held = s_od;
    for (int h = 0; h < hold; h++) begin
      req = 1'b1; in_mode = ~mode; in_data = {$urandom, $urandom};
      @(posedge clk); #1;
      dones += int'(s_done);
      check("bp_data_stable", s_od, held);
      check("bp_flags", {61'd0, s_ov, s_rdy, s_busy}, 64'b101);
    end
    req = 1'b0;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    dones += int'(s_done);
    check("idle_after_handshake", {61'd0, s_rdy, s_busy, s_ov}, 64'b100);
  endtask

  typedef struct {
    logic        mode;
    logic [63:0] d;
    logic [127:0] k;
    logic [63:0] exp;
    int          lat;
    logic        hit;
  } vec_t;

  localparam logic [127:0] KF80 = 128'hFFFF_FFFF_FFFF_FFFF_FFFF;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    logic [63:0]  res, pt, ct;
    logic [127:0] k;
    int           lat, dones;
    logic         hit;

    for (int i = 0; i < 16; i++) isb[sb[i]] = 4'(i);
    req = 1'b0; sel128 = 1'b0; in_mode = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;

    repeat (3) @(posedge clk); #1;
    check("rst_flags80",  {59'd0, ov80, done80, busy80, hit80, rdy80}, 64'b00001);
    check("rst_data80",   od80, 64'd0);
    check("rst_flags128", {59'd0, ov128, done128, busy128, hit128, rdy128}, 64'b00001);
    check("rst_data128",  od128, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    vecs[0] = '{1'b1, 64'hE72C46C0F5945049, KF80,   64'h0000000000000000, 63, 1'b0};
    vecs[1] = '{1'b0, 64'h0000000000000000, 128'd0, 64'h5579C1387B228445, 32, 1'b0};
    vecs[2] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, KF80,   64'h3333DCD3213210D2, 32, 1'b0};
    vecs[3] = '{1'b1, 64'h3333DCD3213210D2, KF80,   64'hFFFFFFFFFFFFFFFF, 32, 1'b1};
    vecs[4] = '{1'b1, 64'h5579C1387B228445, 128'd0, 64'h0000000000000000, 63, 1'b0};
    vecs[5] = '{1'b1, 64'h5579C1387B228445, 128'd0, 64'h0000000000000000, 32, 1'b1};
    foreach (vecs[i]) begin
      run_op(vecs[i].mode, vecs[i].d, vecs[i].k, 0, res, lat, hit, dones);
      check($sformatf("kat%0d_data", i), res, vecs[i].exp);
      check($sformatf("kat%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("kat%0d_cache_hit", i), 64'(hit), 64'(vecs[i].hit));
      check($sformatf("kat%0d_done_count", i), 64'(dones), 64'd1);
    end

    // Backpressure: result must hold for 10 cycles while new requests are ignored.
    k = {$urandom, $urandom, $urandom, $urandom} & key_mask(80);
    pt = {$urandom, $urandom};
    run_op(1'b0, pt, k, 10, res, lat, hit, dones);
    check("bp_data", res, m_crypt(pt, k, 80, 0));
    check("bp_latency", 64'(lat), 64'd32);
    check("bp_done_count", 64'(dones), 64'd1);

    // Abort mid-encrypt with reset; the cache must be lost.
    run_op(1'b0, pt, k, 0, res, lat, hit, dones);
    in_mode = 1'b0; in_data = pt; in_key = k; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    repeat (14) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_flags80", {59'd0, ov80, done80, busy80, hit80, rdy80}, 64'b00001);
    check("midrst_data80", od80, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b1, res, k, 0, ct, lat, hit, dones);
    check("post_rst_dec_data", ct, pt);
    check("post_rst_dec_latency", 64'(lat), 64'd63);
    check("post_rst_dec_hit", 64'(hit), 64'd0);

    // 128-bit random encrypt/decrypt round trips, with occasional cold decrypts.
    sel128 = 1'b1;
    for (int i = 0; i < 500; i++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom};
      if (i % 50 == 0) begin
        ct = {$urandom, $urandom};
        run_op(1'b1, ct, k, 0, res, lat, hit, dones);
        check("k128_cold_dec_data", res, m_crypt(ct, k, 128, 1));
        check("k128_cold_dec_latency", 64'(lat), 64'd63);
        check("k128_cold_dec_hit", 64'(hit), 64'd0);
        k = {$urandom, $urandom, $urandom, $urandom};
      end
      run_op(1'b0, pt, k, 0, ct, lat, hit, dones);
      check("k128_enc_data", ct, m_crypt(pt, k, 128, 0));
      check("k128_enc_latency", 64'(lat), 64'd32);
      check("k128_enc_hit", 64'(hit), 64'd0);
      run_op(1'b1, ct, k, 0, res, lat, hit, dones);
      check("k128_dec_data", res, pt);
      check("k128_dec_latency", 64'(lat), 64'd32);
      check("k128_dec_hit", 64'(hit), 64'd1);
      check("k128_dec_done_count", 64'(dones), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
